rv32_progmem_loader: RTL and testbench
======================================

Name: rv32_progmem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts a byte stream from a host link, for example a UART receiver.
- Assembles little-endian 32-bit instruction words and writes them into instruction memory at consecutive word addresses.
- Holds the pipeline stalled until a complete, valid image has been loaded.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- MAGIC, 8'hA5, start-of-image byte.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- rx_valid  input  1  rx_data holds a byte this cycle
- rx_data  input  8  stream byte
- rx_ready  output  1  loader accepts a byte; a byte is taken when rx_valid && rx_ready
- mem_we  output  1  one-cycle instruction-memory write strobe
- mem_addr  output  ADDR_WIDTH  word address of the write
- mem_wdata  output  32  instruction word
- core_stall  output  1  drives the pipeline stall input; high while no valid image is present
- load_done  output  1  level; a complete image has been loaded
- load_error  output  1  level; the image was rejected
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current load

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_stall=1, load_done=0, load_error=0, words_loaded=0.
  - State=IDLE.
- rx_ready is 1 in every state from the first cycle after reset, except ERROR, where it is 0.
- Image format: MAGIC, LEN_LO, LEN_HI, then LEN×4 payload bytes (each word least-significant byte first). With the optional feature, one checksum byte follows.
- States:
  - IDLE: discards accepted bytes that are not MAGIC. An accepted MAGIC moves to LEN_LO and clears words_loaded, the byte counter and the checksum accumulator.
  - LEN_LO: accepted byte goes to len[7:0], then LEN_HI.
  - LEN_HI: accepted byte goes to len[15:8]. Then:
    - len > 2^ADDR_WIDTH → ERROR.
    - len == 0 → DONE (or CHECK if the feature is enabled).
    - otherwise → DATA.
  - DATA: byte k of the current word goes to wdata[8k+7:8k]. On the 4th byte:
    - The next cycle has mem_we=1, mem_addr=words_loaded[ADDR_WIDTH-1:0], mem_wdata=assembled word.
    - words_loaded increments in that same cycle.
    - After the word numbered len, go to DONE (or CHECK).
  - DONE:
    - load_done=1 and core_stall=0 from the cycle the final mem_we is high; for len==0, from the cycle after LEN_HI.
    - An accepted MAGIC restarts the load: core_stall=1 and load_done=0 the next cycle, then LEN_LO.
    - Other bytes are ignored.
  - ERROR: load_error=1, core_stall=1, rx_ready=0. Left only by reset.
- rx_valid low mid-word holds the partial word indefinitely; there is no timeout.
- mem_we is never high for more than one consecutive cycle. Bytes arrive at most one per cycle, so a word completes at most every 4 cycles.
- Address boundary: mem_addr never wraps. len == 2^ADDR_WIDTH writes addresses 0..2^ADDR_WIDTH-1 exactly once.
- Reset mid-load:
  - Returns to IDLE with core_stall=1 and the partial word dropped.
  - Memory contents already written are left as-is.
  - No mem_we occurs in the reset cycle.

Optional Feature:
- Macro: RV32_LOADER_CHECKSUM_EN.
- Defined:
  - The accumulator XORs every accepted payload byte.
  - After the last payload byte (or after LEN_HI when len==0), state CHECK waits for one byte.
  - Byte equals the accumulator → DONE, with load_done rising the cycle after acceptance.
  - Byte differs → ERROR.
  - The final data word is still written to memory before CHECK.
- Undefined: there is no CHECK state or accumulator; the transition is directly to DONE as described above.

Test Plan:
- Reset, then send A5 02 00 13 00 00 00 93 00 10 00 → mem_we pulses twice: addr0=0x00000013, then addr1=0x00100093. After that, load_done=1, core_stall=0 and words_loaded=2.
- Send 00 FF A5 01 00 78 56 34 12 → the first two bytes are ignored. A single write occurs: addr0=0x12345678.
- ADDR_WIDTH=8; send A5 01 01 (len=257) → load_error=1, rx_ready=0 and core_stall=1. No mem_we occurs. Reset clears the error.
- Send A5 00 00 → load_done=1 with zero writes; with the checksum feature, a further byte 00 is needed before load_done=1.
- Checksum feature: send A5 01 00 11 22 33 44 44 → DONE (0x11^0x22^0x33^0x44=0x44). Sending checksum 45 instead → ERROR, even though addr0=0x44332211 was written.
- Mid-load handling:
  - Assert reset after 2 payload bytes of the first word → no write occurs and the loader returns to IDLE.
  - Then stall rx_valid low for 10 cycles mid-word during a fresh load → the word completes correctly once bytes resume.

Source files
------------

// File: rtl/rv32_progmem_loader.sv
// rv32_progmem_loader: turns a MAGIC/LEN-framed host byte stream into 32-bit instruction-memory writes.
// Define RV32_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module rv32_progmem_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_stall,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
`ifdef RV32_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
`endif
    localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

    state_t                r_state, w_state;
    logic [15:0]           r_len, w_len;
    logic [1:0]            r_bcnt, w_bcnt;
    logic [23:0]           r_buf, w_buf;
    logic                  r_rx_ready, w_rx_ready;
    logic                  r_mem_we, w_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic [31:0]           r_mem_wdata, w_mem_wdata;
    logic                  r_core_stall, w_core_stall;
    logic                  r_load_done, w_load_done;
    logic                  r_load_error, w_load_error;
    logic [ADDR_WIDTH:0]   r_wl, w_wl;
`ifdef RV32_LOADER_CHECKSUM_EN
    logic [7:0]            r_acc, w_acc;
`endif

    logic                  w_take;
    logic [16:0]           w_len_full;
    logic [ADDR_WIDTH:0]   w_wl_inc;
    logic                  w_last;

    assign w_take     = rx_valid && r_rx_ready;
    assign w_len_full = {1'b0, rx_data, r_len[7:0]};
    assign w_wl_inc   = r_wl + (ADDR_WIDTH+1)'(1);
    assign w_last     = 17'(w_wl_inc) == {1'b0, r_len};

    always_comb begin
        w_state      = r_state;
        w_len        = r_len;
        w_bcnt       = r_bcnt;
        w_buf        = r_buf;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_core_stall = r_core_stall;
        w_load_done  = r_load_done;
        w_load_error = r_load_error;
        w_wl         = r_wl;
`ifdef RV32_LOADER_CHECKSUM_EN
        w_acc        = r_acc;
`endif
        if (w_take) begin
            case (r_state)
                IDLE, DONE: begin
                    if (rx_data == MAGIC) begin
                        w_state      = LEN_LO;
                        w_wl         = '0;
                        w_bcnt       = 2'd0;
                        w_core_stall = 1'b1;
                        w_load_done  = 1'b0;
`ifdef RV32_LOADER_CHECKSUM_EN
                        w_acc        = 8'h00;
`endif
                    end
                end
                LEN_LO: begin
                    w_len[7:0] = rx_data;
                    w_state    = LEN_HI;
                end
                LEN_HI: begin
                    w_len[15:8] = rx_data;
                    if (w_len_full > CAP) begin
                        w_state      = ERROR;
                        w_load_error = 1'b1;
                        w_core_stall = 1'b1;
                    end else if (w_len_full == 17'd0) begin
`ifdef RV32_LOADER_CHECKSUM_EN
                        w_state      = CHECK;
`else
                        w_state      = DONE;
                        w_load_done  = 1'b1;
                        w_core_stall = 1'b0;
`endif
                    end else begin
                        w_state = DATA;
                    end
                end
                DATA: begin
                    // Bytes shift in from the top so the first byte ends up least significant.
                    w_buf  = {rx_data, r_buf[23:8]};
                    w_bcnt = r_bcnt + 2'd1;
`ifdef RV32_LOADER_CHECKSUM_EN
                    w_acc  = r_acc ^ rx_data;
`endif
                    if (r_bcnt == 2'd3) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = r_wl[ADDR_WIDTH-1:0];
                        w_mem_wdata = {rx_data, r_buf};
                        w_wl        = w_wl_inc;
                        if (w_last) begin
`ifdef RV32_LOADER_CHECKSUM_EN
                            w_state      = CHECK;
`else
                            w_state      = DONE;
                            w_load_done  = 1'b1;
                            w_core_stall = 1'b0;
`endif
                        end
                    end
                end
`ifdef RV32_LOADER_CHECKSUM_EN
                CHECK: begin
                    w_state      = (rx_data == r_acc) ? DONE : ERROR;
                    w_load_done  = rx_data == r_acc;
                    w_core_stall = rx_data != r_acc;
                    w_load_error = rx_data != r_acc;
                end
`endif
                default: ;
            endcase
        end
        w_rx_ready = w_state != ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_bcnt       <= '0;
            r_buf        <= '0;
            r_rx_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_stall <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_wl         <= '0;
`ifdef RV32_LOADER_CHECKSUM_EN
            r_acc        <= '0;
`endif
        end else begin
            r_state      <= w_state;
            r_len        <= w_len;
            r_bcnt       <= w_bcnt;
            r_buf        <= w_buf;
            r_rx_ready   <= w_rx_ready;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_core_stall <= w_core_stall;
            r_load_done  <= w_load_done;
            r_load_error <= w_load_error;
            r_wl         <= w_wl;
`ifdef RV32_LOADER_CHECKSUM_EN
            r_acc        <= w_acc;
`endif
        end
    end

    assign rx_ready     = r_rx_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign core_stall   = r_core_stall;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_wl;
endmodule

// File: tb/tb_rv32_progmem_loader.sv
// tb_rv32_progmem_loader: directed byte streams; expected memory writes go through a scoreboard queue.
// Honours RV32_LOADER_CHECKSUM_EN by appending the checksum bytes the loader then requires.
module tb_rv32_progmem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_stall;
    logic        load_done;
    logic        load_error;
    logic [8:0]  words_loaded;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    logic prev_we = 1'b0;

    rv32_progmem_loader #(.ADDR_WIDTH(8), .MAGIC(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_stall(core_stall),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we && prev_we) begin
            total++;
            bad++;
            $display("FAIL we_back_to_back act=1 exp=0");
        end
        if (mem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write act=%h@%h exp=none", mem_wdata, mem_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write act=%h@%h exp=%h@%h", mem_wdata, mem_addr, e.d, e.a);
                end
            end
        end
        prev_we = mem_we;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout act=0 exp=1");
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_stall", 32'(core_stall), 1);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_error", 32'(load_error), 0);
        chk("rst_words", 32'(words_loaded), 0);
        chk("rst_addr_data", 32'(mem_addr) | mem_wdata, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] acc;
        do_reset();
        // Two-word image
        expect_wr(8'd0, 32'h00000013);
        expect_wr(8'd1, 32'h00100093);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
`ifdef RV32_LOADER_CHECKSUM_EN
        send(8'h90);
`endif
        idle(2);
        chk("t1_done", 32'(load_done), 1);
        chk("t1_stall", 32'(core_stall), 0);
        chk("t1_words", 32'(words_loaded), 2);
        chk("t1_q", exp_q.size(), 0);
        // Junk bytes ignored, then reload from DONE
        expect_wr(8'd0, 32'h12345678);
        send(8'h00); send(8'hFF);
        idle(1);
        chk("t2_junk_done", 32'(load_done), 1);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h78);
        idle(3);
        chk("t2_restart_stall", 32'(core_stall), 1);
        chk("t2_restart_done", 32'(load_done), 0);
        chk("t2_restart_words", 32'(words_loaded), 0);
        send(8'h56); send(8'h34); send(8'h12);
`ifdef RV32_LOADER_CHECKSUM_EN
        send(8'h08);
`endif
        idle(2);
        chk("t2_done", 32'(load_done), 1);
        chk("t2_words", 32'(words_loaded), 1);
        chk("t2_q", exp_q.size(), 0);
        // Oversize length
        do_reset();
        send(8'hA5); send(8'h01); send(8'h01);
        idle(3);
        chk("t3_error", 32'(load_error), 1);
        chk("t3_rx_ready", 32'(rx_ready), 0);
        chk("t3_stall", 32'(core_stall), 1);
        chk("t3_done", 32'(load_done), 0);
        do_reset();
        idle(2);
        chk("t3_cleared", 32'(load_error), 0);
        chk("t3_ready_again", 32'(rx_ready), 1);
        // Empty image
        send(8'hA5); send(8'h00); send(8'h00);
        idle(2);
`ifdef RV32_LOADER_CHECKSUM_EN
        chk("t4_wait_check", 32'(load_done), 0);
        send(8'h00);
        idle(2);
`endif
        chk("t4_done", 32'(load_done), 1);
        chk("t4_words", 32'(words_loaded), 0);
        chk("t4_stall", 32'(core_stall), 0);
        // One word with checksum 0x44
        expect_wr(8'd0, 32'h44332211);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef RV32_LOADER_CHECKSUM_EN
        send(8'h44);
`endif
        idle(2);
        chk("t5_done", 32'(load_done), 1);
        chk("t5_q", exp_q.size(), 0);
`ifdef RV32_LOADER_CHECKSUM_EN
        expect_wr(8'd0, 32'h44332211);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h45);
        idle(2);
        chk("t5_bad_sum_error", 32'(load_error), 1);
        chk("t5_bad_sum_done", 32'(load_done), 0);
        chk("t5_bad_sum_q", exp_q.size(), 0);
        do_reset();
`endif
        // Reset mid-word drops the partial word
        send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        idle(1);
        do_reset();
        idle(2);
        chk("t6_stall", 32'(core_stall), 1);
        chk("t6_words", 32'(words_loaded), 0);
        chk("t6_q", exp_q.size(), 0);
        // rx_valid gap mid-word
        expect_wr(8'd0, 32'hDEADBEEF);
        send(8'hA5); send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
        idle(10);
        chk("t7_gap_words", 32'(words_loaded), 0);
        chk("t7_gap_stall", 32'(core_stall), 1);
        send(8'hAD); send(8'hDE);
`ifdef RV32_LOADER_CHECKSUM_EN
        send(8'h22);
`endif
        idle(2);
        chk("t7_done", 32'(load_done), 1);
        chk("t7_q", exp_q.size(), 0);
        // Full-capacity image: addresses 0..255 exactly once
        acc = 8'h00;
        for (int i = 0; i < 256; i++)
            expect_wr(8'(i), {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3});
        send(8'hA5); send(8'h00); send(8'h01);
        for (int i = 0; i < 256; i++) begin
            send(8'hC3); send(8'(i) ^ 8'h5A); send(~8'(i)); send(8'(i));
            acc = acc ^ 8'hC3 ^ (8'(i) ^ 8'h5A) ^ ~8'(i) ^ 8'(i);
        end
`ifdef RV32_LOADER_CHECKSUM_EN
        send(acc);
`endif
        idle(2);
        chk("t8_done", 32'(load_done), 1);
        chk("t8_error", 32'(load_error), 0);
        chk("t8_words", 32'(words_loaded), 256);
        chk("t8_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
